// File: rtl/abc_seq_driver_if.sv
// Bundle of signals between the ABC symbol sequence driver and its environment.
// slave is the driver's view; master is the view of whatever loads and observes it.
interface abc_seq_driver_if;
  logic       wr_en;
  logic [2:0] wr_data;
  logic       go;
  logic       clr;
  logic       m;
  logic       n;
  logic       p;
  logic [2:0] rd_addr;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       full;
  logic       err;
  logic [2:0] rd_data;

  modport slave (
    input  wr_en, wr_data, go, clr, m, n, p, rd_addr,
    output a, b, c, busy, done, count, full, err, rd_data
  );

  modport master (
    output wr_en, wr_data, go, clr, m, n, p, rd_addr,
    input  a, b, c, busy, done, count, full, err, rd_data
  );
endinterface

// File: rtl/abc_seq_driver.sv
// Loads up to 8 {a,b,c} symbols and replays them one per cycle into an FSM under test.
// Optional response capture of {m,n,p} per symbol is enabled by defining ABC_SEQ_CAPTURE_EN.
module abc_seq_driver (
  input  logic             clk,
  input  logic             rst,
  abc_seq_driver_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] r_state;
  logic [2:0] r_idx;
  logic [3:0] r_count;
  logic       r_err;
  logic [2:0] r_abc;
  logic       r_busy;
  logic       r_done;
  logic [2:0] r_buf [8];

  logic       w_wr_ok;
  logic       w_last;
  logic [2:0] w_idx_nxt;

  // A write lands only when idle and not overridden by clr or go.
  assign w_wr_ok   = (r_state == IDLE) && !bus.clr && !bus.go && bus.wr_en && !r_count[3];
  assign w_last    = ({1'b0, r_idx} == (r_count - 4'd1));
  assign w_idx_nxt = r_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_count <= 4'd0;
      r_err   <= 1'b0;
      r_abc   <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.clr) begin
            r_count <= 4'd0;
            r_err   <= 1'b0;
          end else if (bus.go) begin
            if (bus.wr_en) r_err <= 1'b1;
            r_idx <= 3'd0;
            if (r_count != 4'd0) begin
              r_state <= PLAY;
              r_abc   <= r_buf[0];
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else if (bus.wr_en) begin
            if (!r_count[3]) r_count <= r_count + 4'd1;
            else             r_err   <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.wr_en) r_err <= 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_abc   <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= w_idx_nxt;
            r_abc <= r_buf[w_idx_nxt];
          end
        end
        DONE: begin
          if (bus.wr_en) r_err <= 1'b1;
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_abc   <= 3'b000;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Symbol storage is plain data: no reset, contents survive playbacks.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_buf[r_count[2:0]] <= bus.wr_data;
  end

`ifdef ABC_SEQ_CAPTURE_EN
  logic [2:0] r_cap [8];

  // r_idx names the symbol being driven this cycle, so its response lands at the closing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_cap[i] <= 3'b000;
    end else if (r_state == PLAY) begin
      r_cap[r_idx] <= {bus.m, bus.n, bus.p};
    end
  end

  assign bus.rd_data = r_cap[bus.rd_addr];
`else
  logic w_unused_rsp;
  assign w_unused_rsp = ^{bus.m, bus.n, bus.p, bus.rd_addr};
  assign bus.rd_data  = 3'b000;
`endif

  assign bus.a     = r_abc[2];
  assign bus.b     = r_abc[1];
  assign bus.c     = r_abc[0];
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign bus.full  = (r_count == 4'd8);
  assign bus.err   = r_err;

endmodule

// File: tb/tb_abc_seq_driver.sv
// Directed scoreboard bench for abc_seq_driver: stimulus pushes the expected post-edge
// outputs, a monitor pops and compares one entry after every rising edge.
module tb_abc_seq_driver;

`ifdef ABC_SEQ_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  abc_seq_driver_if bus ();

  abc_seq_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The FSM under test is modelled as an inverter of the driven symbol.
  assign bus.m = ~bus.a;
  assign bus.n = ~bus.b;
  assign bus.p = ~bus.c;

  typedef struct packed {
    logic [2:0] abc;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic       full;
    logic       err;
    logic       chk_rd;
    logic [2:0] rd;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic cyc(input logic r, input logic w, input logic [2:0] wd, input logic g,
                     input logic c, input logic [2:0] ra,
                     input logic [2:0] eabc, input logic eb, input logic ed,
                     input logic [3:0] ec, input logic ee,
                     input logic chk, input logic [2:0] erd);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.wr_en   = w;
    bus.wr_data = wd;
    bus.go      = g;
    bus.clr     = c;
    bus.rd_addr = ra;
    e.abc    = eabc;
    e.busy   = eb;
    e.done   = ed;
    e.count  = ec;
    e.full   = (ec == 4'd8);
    e.err    = ee;
    e.chk_rd = chk;
    e.rd     = erd;
    q.push_back(e);
  endtask

  task automatic idle(input logic [2:0] eabc, input logic eb, input logic ed,
                      input logic [3:0] ec, input logic ee);
    cyc(0, 0, 3'b000, 0, 0, 3'd0, eabc, eb, ed, ec, ee, 0, 3'b000);
  endtask

  task automatic wr(input logic [2:0] wd, input logic [3:0] ec, input logic ee);
    cyc(0, 1, wd, 0, 0, 3'd0, 3'b000, 0, 0, ec, ee, 0, 3'b000);
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0] got_abc;
    bit bad;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        got_abc = {bus.a, bus.b, bus.c};
        bad = (got_abc !== e.abc) || (bus.busy !== e.busy) || (bus.done !== e.done) ||
              (bus.count !== e.count) || (bus.full !== e.full) || (bus.err !== e.err) ||
              (e.chk_rd && (bus.rd_data !== e.rd));
        vectors++;
        if (bad) begin
          miscompares++;
          $display("FAIL vec%0d: got abc=%b busy=%b done=%b count=%0d full=%b err=%b rd=%b ; want abc=%b busy=%b done=%b count=%0d full=%b err=%b rd=%b(chk=%b)",
                   vectors, got_abc, bus.busy, bus.done, bus.count, bus.full, bus.err, bus.rd_data,
                   e.abc, e.busy, e.done, e.count, e.full, e.err, e.rd, e.chk_rd);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = 3'b000; bus.go = 1'b0; bus.clr = 1'b0; bus.rd_addr = 3'd0;

    // Reset state
    cyc(1, 0, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0, 4'd0, 0, 1, 3'b000);
    cyc(1, 0, 3'b000, 0, 0, 3'd5, 3'b000, 0, 0, 4'd0, 0, 1, 3'b000);

    // Basic 3-symbol playback, done lands at go-edge + count + 1
    wr(3'b100, 4'd1, 0);
    wr(3'b010, 4'd2, 0);
    wr(3'b001, 4'd3, 0);
    cyc(0, 0, 3'b000, 1, 0, 3'd0, 3'b100, 1, 0, 4'd3, 0, 0, 3'b000);
    idle(3'b010, 1, 0, 4'd3, 0);
    idle(3'b001, 1, 0, 4'd3, 0);
    idle(3'b000, 0, 1, 4'd3, 0);
    idle(3'b000, 0, 0, 4'd3, 0);

    // Capture: play 110,011 with inverted responses
    cyc(0, 0, 3'b000, 0, 1, 3'd0, 3'b000, 0, 0, 4'd0, 0, 0, 3'b000);
    wr(3'b110, 4'd1, 0);
    wr(3'b011, 4'd2, 0);
    cyc(0, 0, 3'b000, 1, 0, 3'd0, 3'b110, 1, 0, 4'd2, 0, 0, 3'b000);
    idle(3'b011, 1, 0, 4'd2, 0);
    idle(3'b000, 0, 1, 4'd2, 0);
    idle(3'b000, 0, 0, 4'd2, 0);
    cyc(0, 0, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0, 4'd2, 0, 1, CAP ? 3'b001 : 3'b000);
    cyc(0, 0, 3'b000, 0, 0, 3'd1, 3'b000, 0, 0, 4'd2, 0, 1, CAP ? 3'b100 : 3'b000);
    // Entry 2 beyond count keeps the response from the earlier 3-symbol run (~001)
    cyc(0, 0, 3'b000, 0, 0, 3'd2, 3'b000, 0, 0, 4'd2, 0, 1, CAP ? 3'b110 : 3'b000);

    // go with an empty buffer
    cyc(0, 0, 3'b000, 0, 1, 3'd0, 3'b000, 0, 0, 4'd0, 0, 0, 3'b000);
    cyc(0, 0, 3'b000, 1, 0, 3'd0, 3'b000, 0, 1, 4'd0, 0, 0, 3'b000);
    idle(3'b000, 0, 0, 4'd0, 0);

    // Overfill: nine writes, ninth dropped with err
    for (int i = 0; i < 9; i++) begin
      logic [3:0] ec;
      logic [2:0] wd;
      ec = (i < 8) ? 4'(i + 1) : 4'd8;
      wd = (i < 8) ? 3'(i) : 3'b101;
      wr(wd, ec, (i == 8));
    end
    cyc(0, 0, 3'b000, 0, 1, 3'd0, 3'b000, 0, 0, 4'd0, 0, 0, 3'b000);

    // Protocol abuse during a 5-symbol playback
    wr(3'b001, 4'd1, 0);
    wr(3'b010, 4'd2, 0);
    wr(3'b011, 4'd3, 0);
    wr(3'b100, 4'd4, 0);
    wr(3'b101, 4'd5, 0);
    cyc(0, 0, 3'b000, 1, 0, 3'd0, 3'b001, 1, 0, 4'd5, 0, 0, 3'b000);
    cyc(0, 1, 3'b111, 1, 0, 3'd0, 3'b010, 1, 0, 4'd5, 1, 0, 3'b000);
    cyc(0, 0, 3'b000, 0, 1, 3'd0, 3'b011, 1, 0, 4'd5, 1, 0, 3'b000);
    idle(3'b100, 1, 0, 4'd5, 1);
    cyc(0, 0, 3'b000, 1, 0, 3'd0, 3'b101, 1, 0, 4'd5, 1, 0, 3'b000);
    cyc(0, 0, 3'b000, 1, 0, 3'd0, 3'b000, 0, 1, 4'd5, 1, 0, 3'b000);
    cyc(0, 0, 3'b000, 1, 1, 3'd0, 3'b000, 0, 0, 4'd5, 1, 0, 3'b000);
    idle(3'b000, 0, 0, 4'd5, 1);

    // go + wr_en in IDLE: playback starts, write dropped, err set
    cyc(0, 0, 3'b000, 0, 1, 3'd0, 3'b000, 0, 0, 4'd0, 0, 0, 3'b000);
    wr(3'b111, 4'd1, 0);
    wr(3'b110, 4'd2, 0);
    cyc(0, 1, 3'b001, 1, 0, 3'd0, 3'b111, 1, 0, 4'd2, 1, 0, 3'b000);
    idle(3'b110, 1, 0, 4'd2, 1);
    idle(3'b000, 0, 1, 4'd2, 1);
    idle(3'b000, 0, 0, 4'd2, 1);

    // clr + go in IDLE: clr wins, no playback
    cyc(0, 0, 3'b000, 1, 1, 3'd0, 3'b000, 0, 0, 4'd0, 0, 0, 3'b000);
    idle(3'b000, 0, 0, 4'd0, 0);

    // Reset in the second PLAY cycle aborts without a done pulse
    wr(3'b101, 4'd1, 0);
    wr(3'b011, 4'd2, 0);
    wr(3'b111, 4'd3, 0);
    cyc(0, 0, 3'b000, 1, 0, 3'd0, 3'b101, 1, 0, 4'd3, 0, 0, 3'b000);
    idle(3'b011, 1, 0, 4'd3, 0);
    cyc(1, 0, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0, 4'd0, 0, 1, 3'b000);
    cyc(0, 0, 3'b000, 0, 0, 3'd1, 3'b000, 0, 0, 4'd0, 0, 1, 3'b000);
    cyc(0, 0, 3'b000, 0, 0, 3'd2, 3'b000, 0, 0, 4'd0, 0, 1, 3'b000);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/abc_seq_driver.md
ABC_SEQ_DRIVER -- requirements
Module: abc_seq_driver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed below in order.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wr_en  input  1  append wr_data to the symbol buffer.
REQ-005 wr_data  input  3  symbol, bit2=a, bit1=b, bit0=c.
REQ-006 go  input  1  start playback of the loaded symbols.
REQ-007 clr  input  1  empty the buffer and clear err.
REQ-008 m, n, p  input  1 each  responses of the driven FSM, sampled for capture.
REQ-009 rd_addr  input  3  capture buffer read index.
REQ-010 a, b, c  output  1 each  registered symbol drive to the FSM under test.
REQ-011 busy  output  1  playback in progress.
REQ-012 done  output  1  one-cycle pulse at end of playback.
REQ-013 count  output  4  number of loaded symbols, 0..8.
REQ-014 full  output  1  count==8.
REQ-015 err  output  1  sticky protocol-error flag.
REQ-016 rd_data  output  3  {m,n,p} captured for symbol rd_addr, combinational read.

Function
REQ-017 The block SHALL implement states IDLE, PLAY, DONE; the 8-entry x 3-bit symbol buffer keeps its contents across playbacks.
REQ-018 In IDLE, wr_en with count<8 SHALL store wr_data at buf[count] and increment count at the edge.
REQ-019 wr_en with count==8, or in PLAY/DONE, SHALL drop the write and set err.
REQ-020 In IDLE, go with count>0 SHALL move to PLAY with index 0; in the next cycle busy=1 and {a,b,c}=buf[0].
REQ-021 In PLAY, the cycle k after entry SHALL drive buf[k] on {a,b,c} for exactly one cycle, k=0..count-1.
REQ-022 After buf[count-1] is driven, the next cycle SHALL be DONE: {a,b,c}=000, busy=0, done=1; the following cycle returns to IDLE with done=0.
REQ-023 In IDLE, go with count==0 SHALL produce DONE for one cycle (done=1) with no symbol driven.
REQ-024 In IDLE, go and wr_en in the same cycle: go SHALL win, the write is dropped, err set.
REQ-025 In IDLE, clr SHALL set count=0 and err=0; clr with go in the same cycle: clr wins, no playback.
REQ-026 go and clr in PLAY or DONE SHALL be ignored and SHALL NOT set err.
REQ-027 In IDLE and DONE, {a,b,c} SHALL be 000.
REQ-028 Total latency: go sampled at edge E -> done high in cycle E+count+1.

Reset
REQ-029 rst SHALL force IDLE, a=b=c=0, busy=0, done=0, count=0, full=0, err=0, and all capture entries to 000; buffer contents undefined.
REQ-030 rst during PLAY SHALL abort at that edge with no done pulse.

Configuration
REQ-031 With macro ABC_SEQ_CAPTURE_EN defined: at the edge ending the cycle where buf[k] is driven, {m,n,p} SHALL be written to cap[k]; entries k>=count keep their previous values; rd_data=cap[rd_addr].
REQ-032 Without ABC_SEQ_CAPTURE_EN: the capture storage SHALL be absent, m/n/p ignored, and rd_data tied to 000; all other behaviour is unchanged.

Verification
REQ-033 Reset, write 100,010,001, then go -> busy=1 for 3 cycles with abc=100,010,001 in order, then done=1 with abc=000, count stays 3.
REQ-034 Write 9 symbols -> count=8, full=1, 9th dropped, err=1; clr -> count=0, err=0.
REQ-035 go with count==0 -> done=1 next cycle, busy stays 0, abc=000.
REQ-036 During a 5-symbol playback, pulse wr_en and go -> sequence unchanged, err=1, no restart; go+wr_en in IDLE -> playback starts, write dropped, err=1.
REQ-037 rst asserted in the 2nd PLAY cycle -> next cycle all outputs 0, no done pulse, count=0.
REQ-038 With ABC_SEQ_CAPTURE_EN, tie {m,n,p}={a,b,c} inverted, play 110,011 -> rd_addr 0/1 return 001/100; without the macro rd_data=000.
